wb_burst_master: RTL
====================

WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter dw, default 32: Wishbone data width in bits, multiple of 8.
REQ-002 Parameter TIMEOUT, default 1023: max cycles wb_stb_o may wait for wb_ack_i.
REQ-003 sys_clk  in  1  sole clock; all state on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both high.
REQ-006 cmd_addr  in  26  start byte address.
REQ-007 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_len  in  8  beats minus one (0 = 1 beat, 255 = 256 beats).
REQ-009 wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / dw  write-data stream.
REQ-010 rd_valid / rd_data  out / out  1 / dw  read-data stream; no backpressure.
REQ-011 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe, write enable.
REQ-012 wb_addr_o  out  26; wb_dat_o  out  dw; wb_sel_o  out  dw/8; wb_cti_o  out  3.
REQ-013 wb_ack_i  in  1; wb_dat_i  in  dw  slave acknowledge and read data.
REQ-014 busy  out  1  state != IDLE; err  out  1  one-cycle timeout pulse.

Function
REQ-015 States: IDLE, RD_BURST, WR_BURST; all outputs registered except cmd_ready, wr_ready.
REQ-016 cmd_ready = (state == IDLE); accepted command latches addr, we, beat counter = cmd_len.
REQ-017 IDLE->RD_BURST on read accept: next cycle wb_cyc_o = wb_stb_o = 1, wb_we_o = 0, wb_addr_o = cmd_addr.
REQ-018 IDLE->WR_BURST on write accept: wb_cyc_o = 1 next cycle; wb_stb_o rises only once a beat is loaded.
REQ-019 wr_ready = (state == WR_BURST) && beats remain unloaded && (!wb_stb_o || wb_ack_i).
REQ-020 wr_valid && wr_ready loads wr_data into wb_dat_o and sets wb_stb_o next cycle; otherwise ack clears wb_stb_o.
REQ-021 Each wb_ack_i while wb_stb_o high: wb_addr_o += dw/8 (modulo 2^26, wraps silently), counter decrements.
REQ-022 wb_cti_o = 3'b010 for every beat except the last; 3'b111 on the last (and only) beat.
REQ-023 wb_sel_o = all ones whenever wb_stb_o high; zero otherwise.
REQ-024 Read: ack pulses rd_valid the next cycle with rd_data = wb_dat_i sampled at the ack; one rd_valid per beat.
REQ-025 Ack on last beat: wb_cyc_o, wb_stb_o, wb_cti_o clear next cycle; state -> IDLE; cmd_ready high that same cycle.
REQ-026 wb_ack_i while wb_stb_o low is ignored (no count, no data).
REQ-027 Timeout counter clears on every ack or strobe rise; counts while wb_stb_o high; at TIMEOUT: cyc/stb drop, err pulses 1 cycle, state -> IDLE, remaining beats discarded.
REQ-028 Write burst stalled by wr_valid low keeps wb_cyc_o high with wb_stb_o low; no timeout accrues.

Reset
REQ-029 RESET forces state IDLE and all outputs 0 (wb_cti_o = 3'b000, cmd_ready = 1 after release) immediately, including mid-burst.
REQ-030 After RESET deassertion no residual rd_valid or err pulse appears.

Structure
REQ-031 Shared package wb_pkg holds state enum, CTI constants (CTI_CLASSIC = 000, CTI_INCR = 010, CTI_EOB = 111) and address width 26.
REQ-032 Single module; timeout counter may be sub-module wb_timeout_cnt (parameter TIMEOUT, inputs run/clear, output expired).

Verification
REQ-033 Read addr 0x000100, len 3, slave acks every cycle -> 4 rd_valid, wb_addr_o 0x100/0x104/0x108/0x10C, cti 010,010,010,111.
REQ-034 Write len 0, data 0xDEADBEEF -> one strobe with cti 111, wb_dat_o 0xDEADBEEF, sel 0xF, back to IDLE next cycle after ack.
REQ-035 Write len 7, wr_valid toggling every other cycle -> 8 acked beats in order, stb low in gaps, cyc high throughout.
REQ-036 Read at addr 0x3FFFFFC, len 1 -> second beat at 0x0000000.
REQ-037 Slave never acks, TIMEOUT = 15 -> cyc/stb drop 15 cycles after strobe rise, err pulses once, cmd_ready returns high.
REQ-038 RESET asserted on beat 2 of a 4-beat read -> cyc/stb/rd_valid low in the same cycle; new command after release completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone burst definitions: FSM state encodings, cycle-type identifiers and
// the byte-address width used by the burst master.
package wb_pkg;

  localparam int unsigned AW = 26;

  typedef logic [1:0] wb_state_t;

  localparam wb_state_t ST_IDLE     = 2'd0;
  localparam wb_state_t ST_RD_BURST = 2'd1;
  localparam wb_state_t ST_WR_BURST = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic logic [2:0] beat_cti(input logic last);
    return last ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Strobe watchdog: counts cycles a strobe waits for acknowledge and flags expiry on the
// edge that would complete TIMEOUT waiting cycles.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic sys_clk,
  input  logic RESET,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge sys_clk or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The owner drops the strobe on this edge, which clears the count again.
  assign expired = run && !clear && (r_cnt == LIMIT);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master: accepts one read or write command, runs the burst
// with registered bus outputs and aborts with an err pulse if the slave stops acknowledging.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned dw      = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic            sys_clk,
  input  logic            RESET,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic            cmd_we,
  input  logic [7:0]      cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [dw-1:0]   wr_data,
  output logic            rd_valid,
  output logic [dw-1:0]   rd_data,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [dw-1:0]   wb_dat_i,
  output logic            busy,
  output logic            err
);

  localparam int unsigned SW = dw / 8;

  wb_state_t     r_state, w_state_nxt;
  logic          r_cyc, w_cyc_nxt;
  logic          r_stb, w_stb_nxt;
  logic          r_we, w_we_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [dw-1:0] r_dat, w_dat_nxt;
  logic [SW-1:0] r_sel, w_sel_nxt;
  logic [2:0]    r_cti, w_cti_nxt;
  logic          r_rd_valid, w_rd_valid_nxt;
  logic [dw-1:0] r_rd_data, w_rd_data_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_err, w_err_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;   // acked beats still owed, minus one
  logic [8:0]    r_unl, w_unl_nxt;   // write beats not yet loaded onto the bus

  logic          w_ack;
  logic          w_last;
  logic          w_load;
  logic          w_expired;
  logic [AW-1:0] w_addr_inc;

  assign w_ack      = r_stb && wb_ack_i;
  assign w_last     = (r_cnt == 8'd0);
  assign w_addr_inc = r_addr + AW'(SW);

  assign cmd_ready = (r_state == ST_IDLE) && !RESET;
  assign wr_ready  = (r_state == ST_WR_BURST) && (r_unl != 9'd0) && (!r_stb || wb_ack_i);
  assign w_load    = wr_valid && wr_ready;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .sys_clk (sys_clk),
    .RESET   (RESET),
    .run     (r_stb),
    .clear   (!r_stb || wb_ack_i),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cyc_nxt      = r_cyc;
    w_stb_nxt      = r_stb;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_dat_nxt      = r_dat;
    w_cti_nxt      = r_cti;
    w_rd_valid_nxt = 1'b0;
    w_rd_data_nxt  = r_rd_data;
    w_busy_nxt     = r_busy;
    w_err_nxt      = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_unl_nxt      = r_unl;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_addr_nxt = cmd_addr;
          w_we_nxt   = cmd_we;
          w_cnt_nxt  = cmd_len;
          w_cyc_nxt  = 1'b1;
          w_busy_nxt = 1'b1;
          w_cti_nxt  = beat_cti(cmd_len == 8'd0);
          if (cmd_we) begin
            w_state_nxt = ST_WR_BURST;
            w_stb_nxt   = 1'b0;
            w_unl_nxt   = {1'b0, cmd_len} + 9'd1;
          end else begin
            w_state_nxt = ST_RD_BURST;
            w_stb_nxt   = 1'b1;
            w_unl_nxt   = 9'd0;
          end
        end
      end

      ST_RD_BURST: begin
        if (w_ack) begin
          w_rd_valid_nxt = 1'b1;
          w_rd_data_nxt  = wb_dat_i;
          w_addr_nxt     = w_addr_inc;
          if (!w_last) begin
            w_cnt_nxt = r_cnt - 8'd1;
            w_cti_nxt = beat_cti(r_cnt == 8'd1);
          end
        end
      end

      ST_WR_BURST: begin
        if (w_ack) begin
          w_addr_nxt = w_addr_inc;
          w_stb_nxt  = 1'b0;
          if (!w_last) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        // A new beat may be loaded on the same edge the previous one is acked.
        if (w_load) begin
          w_dat_nxt = wr_data;
          w_stb_nxt = 1'b1;
          w_unl_nxt = r_unl - 9'd1;
          w_cti_nxt = beat_cti(r_unl == 9'd1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if ((r_state != ST_IDLE) && ((w_ack && w_last) || w_expired)) begin
      w_state_nxt = ST_IDLE;
      w_cyc_nxt   = 1'b0;
      w_stb_nxt   = 1'b0;
      w_we_nxt    = 1'b0;
      w_cti_nxt   = CTI_CLASSIC;
      w_busy_nxt  = 1'b0;
      w_unl_nxt   = 9'd0;
      w_err_nxt   = w_expired;
    end

    w_sel_nxt = w_stb_nxt ? {SW{1'b1}} : {SW{1'b0}};
  end

  always_ff @(posedge sys_clk or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_cti      <= CTI_CLASSIC;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= 8'd0;
      r_unl      <= 9'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cyc      <= w_cyc_nxt;
      r_stb      <= w_stb_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_dat      <= w_dat_nxt;
      r_sel      <= w_sel_nxt;
      r_cti      <= w_cti_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_cnt      <= w_cnt_nxt;
      r_unl      <= w_unl_nxt;
    end
  end

  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = r_we;
  assign wb_addr_o = r_addr;
  assign wb_dat_o  = r_dat;
  assign wb_sel_o  = r_sel;
  assign wb_cti_o  = r_cti;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
